// File: rtl/can_access_arbiter.sv
// Two-port arbiter in front of the single CAN register access engine: latches request
// pulses, grants round-robin (fixed priority to port 0 when CAN_ARB_FIXED_PRIO_EN is defined).

module can_arb_port (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wren_i,
  input  logic        rden_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] din_i,
  input  logic        done_i,
  input  logic        rsp_ld_i,
  input  logic [31:0] rsp_data_i,
  output logic        pend_o,
  output logic        rd_o,
  output logic        drop_o,
  output logic [31:0] addr_o,
  output logic [31:0] din_o,
  output logic [31:0] dout_o
);
  logic        pend_q, pend_d, rd_q, rd_d;
  logic [31:0] addr_q, addr_d, din_q, din_d, dout_q, dout_d;
  logic        req, cap;

  assign req    = wren_i | rden_i;
  assign cap    = req & ~pend_q;
  assign drop_o = req & pend_q;

  always_comb begin
    pend_d = pend_q;
    rd_d   = rd_q;
    addr_d = addr_q;
    din_d  = din_q;
    dout_d = dout_q;
    if (cap) begin
      pend_d = 1'b1;
      rd_d   = rden_i;  // read wins when both strobes are set
      addr_d = addr_i;
      din_d  = din_i;
    end else if (done_i) begin
      pend_d = 1'b0;
    end
    if (rsp_ld_i) dout_d = rsp_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
      dout_q <= '0;
    end else begin
      pend_q <= pend_d;
      rd_q   <= rd_d;
      addr_q <= addr_d;
      din_q  <= din_d;
      dout_q <= dout_d;
    end
  end

  assign pend_o = pend_q;
  assign rd_o   = rd_q;
  assign addr_o = addr_q;
  assign din_o  = din_q;
  assign dout_o = dout_q;
endmodule

module can_access_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter logic [31:0] TO_DATA     = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s0_addr_i,
  input  logic        s0_wren_i,
  input  logic        s0_rden_i,
  input  logic [31:0] s0_din_i,
  output logic        s0_ready_o,
  output logic [31:0] s0_dout_o,
  output logic        s0_valid_o,
  input  logic [31:0] s1_addr_i,
  input  logic        s1_wren_i,
  input  logic        s1_rden_i,
  input  logic [31:0] s1_din_i,
  output logic        s1_ready_o,
  output logic [31:0] s1_dout_o,
  output logic        s1_valid_o,
  output logic [31:0] m_addr_o,
  output logic        m_wren_o,
  output logic        m_rden_o,
  output logic [31:0] m_din_o,
  input  logic [31:0] m_dout_i,
  input  logic        m_valid_i,
  output logic [3:0]  status_o,
  input  logic        clr_i
);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic            gnt_q, gnt_d, pick;
  logic [15:0]     cnt_q, cnt_d;
  logic [31:0]     m_addr_q, m_addr_d, m_din_q, m_din_d;
  logic            m_wren_q, m_wren_d, m_rden_q, m_rden_d;
  logic            to_q, to_d, to_set, rsp_ld;
  logic [1:0]      drop_q, drop_d;
  logic [31:0]     rsp_data;
`ifndef CAN_ARB_FIXED_PRIO_EN
  logic            last_q, last_d;
`endif

  logic [1:0]        s_wren, s_rden, p_pend, p_rd, p_drop, p_done, p_ld;
  logic [1:0][31:0]  s_addr, s_din, p_addr, p_din, p_dout;

  assign s_wren = {s1_wren_i, s0_wren_i};
  assign s_rden = {s1_rden_i, s0_rden_i};
  assign s_addr = {s1_addr_i, s0_addr_i};
  assign s_din  = {s1_din_i,  s0_din_i};

  for (genvar n = 0; n < 2; n++) begin : g_port
    assign p_done[n] = (state_q == RESP) && (gnt_q == n[0]);
    assign p_ld[n]   = rsp_ld && (gnt_q == n[0]);
    can_arb_port u_port (
      .clk(clk), .rst_n(rst_n),
      .wren_i(s_wren[n]), .rden_i(s_rden[n]),
      .addr_i(s_addr[n]), .din_i(s_din[n]),
      .done_i(p_done[n]), .rsp_ld_i(p_ld[n]), .rsp_data_i(rsp_data),
      .pend_o(p_pend[n]), .rd_o(p_rd[n]), .drop_o(p_drop[n]),
      .addr_o(p_addr[n]), .din_o(p_din[n]), .dout_o(p_dout[n])
    );
  end

  always_comb begin
`ifdef CAN_ARB_FIXED_PRIO_EN
    pick = ~p_pend[0];
`else
    pick = (&p_pend) ? ~last_q : p_pend[1];
`endif
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    m_addr_d = m_addr_q;
    m_din_d  = m_din_q;
    m_wren_d = 1'b0;
    m_rden_d = 1'b0;
    rsp_ld   = 1'b0;
    rsp_data = m_dout_i;
    to_set   = 1'b0;
`ifndef CAN_ARB_FIXED_PRIO_EN
    last_d   = last_q;
`endif
    case (state_q)
      IDLE: if (|p_pend) begin
        gnt_d    = pick;
`ifndef CAN_ARB_FIXED_PRIO_EN
        last_d   = pick;
`endif
        m_addr_d = p_addr[pick];
        m_din_d  = p_din[pick];
        m_rden_d = p_rd[pick];
        m_wren_d = ~p_rd[pick];
        state_d  = ISSUE;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 16'd1;
        // a completion in the timeout cycle still delivers real data
        if (m_valid_i) begin
          rsp_ld  = 1'b1;
          state_d = RESP;
        end else if (cnt_q == TO_LAST) begin
          rsp_ld   = 1'b1;
          rsp_data = TO_DATA;
          to_set   = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign to_d   = to_set | (to_q & ~clr_i);
  assign drop_d = p_drop | (drop_q & {2{~clr_i}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      cnt_q    <= '0;
      m_addr_q <= '0;
      m_din_q  <= '0;
      m_wren_q <= 1'b0;
      m_rden_q <= 1'b0;
      to_q     <= 1'b0;
      drop_q   <= '0;
`ifndef CAN_ARB_FIXED_PRIO_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      m_addr_q <= m_addr_d;
      m_din_q  <= m_din_d;
      m_wren_q <= m_wren_d;
      m_rden_q <= m_rden_d;
      to_q     <= to_d;
      drop_q   <= drop_d;
`ifndef CAN_ARB_FIXED_PRIO_EN
      last_q   <= last_d;
`endif
    end
  end

  assign s0_ready_o = ~p_pend[0];
  assign s1_ready_o = ~p_pend[1];
  assign s0_valid_o = p_done[0];
  assign s1_valid_o = p_done[1];
  assign s0_dout_o  = p_dout[0];
  assign s1_dout_o  = p_dout[1];
  assign m_addr_o   = m_addr_q;
  assign m_din_o    = m_din_q;
  assign m_wren_o   = m_wren_q;
  assign m_rden_o   = m_rden_q;
  assign status_o   = {to_q, drop_q[1], drop_q[0], state_q != IDLE};
endmodule

// File: tb/tb_can_access_arbiter.sv
// Directed bench for can_access_arbiter; expectations follow CAN_ARB_FIXED_PRIO_EN when defined.
module tb_can_access_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clr_i;
  logic [31:0] s0_addr_i, s0_din_i, s1_addr_i, s1_din_i, m_dout_i;
  logic        s0_wren_i, s0_rden_i, s1_wren_i, s1_rden_i, m_valid_i;
  logic        s0_ready_o, s0_valid_o, s1_ready_o, s1_valid_o, m_wren_o, m_rden_o;
  logic [31:0] s0_dout_o, s1_dout_o, m_addr_o, m_din_o;
  logic [3:0]  status_o;

  int n_chk = 0, n_fail = 0;
  int rd_cnt = 0, wr_cnt = 0, v0_cnt = 0, v1_cnt = 0;
  int rd0, v00, v10;
  logic exp_first;

  can_access_arbiter #(.TIMEOUT_CYC(16), .TO_DATA(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_addr_i(s0_addr_i), .s0_wren_i(s0_wren_i), .s0_rden_i(s0_rden_i), .s0_din_i(s0_din_i),
    .s0_ready_o(s0_ready_o), .s0_dout_o(s0_dout_o), .s0_valid_o(s0_valid_o),
    .s1_addr_i(s1_addr_i), .s1_wren_i(s1_wren_i), .s1_rden_i(s1_rden_i), .s1_din_i(s1_din_i),
    .s1_ready_o(s1_ready_o), .s1_dout_o(s1_dout_o), .s1_valid_o(s1_valid_o),
    .m_addr_o(m_addr_o), .m_wren_o(m_wren_o), .m_rden_o(m_rden_o), .m_din_o(m_din_o),
    .m_dout_i(m_dout_i), .m_valid_i(m_valid_i), .status_o(status_o), .clr_i(clr_i)
  );

  always @(negedge clk) begin
    if (m_rden_o) rd_cnt++;
    if (m_wren_o) wr_cnt++;
    if (s0_valid_o) v0_cnt++;
    if (s1_valid_o) v1_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset;
    {s0_wren_i, s0_rden_i, s1_wren_i, s1_rden_i, m_valid_i, clr_i} = '0;
    s0_addr_i = '0; s0_din_i = '0; s1_addr_i = '0; s1_din_i = '0; m_dout_i = '0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    rst_n = 1'b0;
    step();
    n_chk++; if ({s0_ready_o, s1_ready_o} !== 2'b11) begin n_fail++; $display("FAIL rst_ready: got %b want 11", {s0_ready_o, s1_ready_o}); end
    n_chk++; if ({m_rden_o, m_wren_o, s0_valid_o, s1_valid_o} !== 4'b0) begin n_fail++; $display("FAIL rst_pulses: got %b want 0000", {m_rden_o, m_wren_o, s0_valid_o, s1_valid_o}); end
    n_chk++; if (status_o !== 4'b0) begin n_fail++; $display("FAIL rst_status: got %b want 0000", status_o); end
    n_chk++; if ({m_addr_o, m_din_o, s0_dout_o, s1_dout_o} !== 128'b0) begin n_fail++; $display("FAIL rst_data: got %h want 0", {m_addr_o, m_din_o, s0_dout_o, s1_dout_o}); end
    rst_n = 1'b1;
  endtask

  task automatic test_read;
    do_reset();
    rd0 = rd_cnt; v00 = v0_cnt; v10 = v1_cnt;
    s0_addr_i = 32'h02; s0_rden_i = 1'b1;
    step();
    s0_rden_i = 1'b0;
    n_chk++; if (s0_ready_o !== 1'b0) begin n_fail++; $display("FAIL rd_ready_low: got %b want 0", s0_ready_o); end
    n_chk++; if (m_rden_o !== 1'b0) begin n_fail++; $display("FAIL rd_early_pulse: got %b want 0", m_rden_o); end
    step();
    n_chk++; if ({m_rden_o, m_wren_o} !== 2'b10) begin n_fail++; $display("FAIL rd_issue: got %b want 10", {m_rden_o, m_wren_o}); end
    n_chk++; if (m_addr_o !== 32'h02) begin n_fail++; $display("FAIL rd_addr: got %h want 00000002", m_addr_o); end
    n_chk++; if (status_o !== 4'b0001) begin n_fail++; $display("FAIL rd_busy: got %b want 0001", status_o); end
    step();
    n_chk++; if (m_rden_o !== 1'b0) begin n_fail++; $display("FAIL rd_one_cycle: got %b want 0", m_rden_o); end
    step(5);
    m_valid_i = 1'b1; m_dout_i = 32'h0000_000C;
    step();
    m_valid_i = 1'b0; m_dout_i = '0;
    n_chk++; if ({s0_valid_o, s1_valid_o} !== 2'b10) begin n_fail++; $display("FAIL rd_valid: got %b want 10", {s0_valid_o, s1_valid_o}); end
    n_chk++; if (s0_dout_o !== 32'h0000_000C) begin n_fail++; $display("FAIL rd_dout: got %h want 0000000c", s0_dout_o); end
    s0_rden_i = 1'b1;  // request during own response cycle is dropped
    step();
    s0_rden_i = 1'b0;
    n_chk++; if ({s0_valid_o, s0_ready_o} !== 2'b01) begin n_fail++; $display("FAIL rd_after: got valid/ready %b want 01", {s0_valid_o, s0_ready_o}); end
    n_chk++; if (s0_dout_o !== 32'h0000_000C) begin n_fail++; $display("FAIL rd_dout_hold: got %h want 0000000c", s0_dout_o); end
    n_chk++; if (status_o !== 4'b0010) begin n_fail++; $display("FAIL rd_resp_drop: got %b want 0010", status_o); end
    step(3);
    n_chk++; if (rd_cnt - rd0 !== 1) begin n_fail++; $display("FAIL rd_pulse_count: got %0d want 1", rd_cnt - rd0); end
    n_chk++; if ({v0_cnt - v00, v1_cnt - v10} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL rd_valid_count: got %0d/%0d want 1/0", v0_cnt - v00, v1_cnt - v10); end
  endtask

  task automatic test_round_robin;
    do_reset();
    s0_addr_i = 32'h05; s0_din_i = 32'hA5; s0_wren_i = 1'b1;
    s1_addr_i = 32'h03; s1_rden_i = 1'b1;
    step();
    s0_wren_i = 1'b0; s1_rden_i = 1'b0;
    step();
    n_chk++; if ({m_wren_o, m_rden_o, m_addr_o, m_din_o} !== {2'b10, 32'h05, 32'hA5}) begin n_fail++; $display("FAIL rr1_first: got w%b r%b a%h d%h want w1 r0 a05 da5", m_wren_o, m_rden_o, m_addr_o, m_din_o); end
    step();
    m_valid_i = 1'b1; m_dout_i = 32'h11;
    step();
    m_valid_i = 1'b0;
    n_chk++; if ({s0_valid_o, s1_valid_o, s0_dout_o} !== {2'b10, 32'h11}) begin n_fail++; $display("FAIL rr1_resp0: got v%b%b d%h want v10 d11", s0_valid_o, s1_valid_o, s0_dout_o); end
    step(2);
    n_chk++; if ({m_rden_o, m_addr_o} !== {1'b1, 32'h03}) begin n_fail++; $display("FAIL rr1_second: got r%b a%h want r1 a03", m_rden_o, m_addr_o); end
    step();
    m_valid_i = 1'b1; m_dout_i = 32'h22;
    step();
    m_valid_i = 1'b0;
    n_chk++; if ({s1_valid_o, s0_valid_o, s1_dout_o} !== {2'b10, 32'h22}) begin n_fail++; $display("FAIL rr1_resp1: got v%b%b d%h want v10 d22", s1_valid_o, s0_valid_o, s1_dout_o); end
    // solo port-0 transaction moves the round-robin pointer back to port 0
    step();
    s0_addr_i = 32'h08; s0_rden_i = 1'b1;
    step();
    s0_rden_i = 1'b0;
    step(2);
    m_valid_i = 1'b1; m_dout_i = 32'h01;
    step();
    m_valid_i = 1'b0;
    step();
`ifdef CAN_ARB_FIXED_PRIO_EN
    exp_first = 1'b0;
`else
    exp_first = 1'b1;
`endif
    s0_addr_i = 32'h05; s0_wren_i = 1'b1; s1_addr_i = 32'h03; s1_rden_i = 1'b1;
    step();
    s0_wren_i = 1'b0; s1_rden_i = 1'b0;
    step();
    n_chk++; if (m_addr_o !== (exp_first ? 32'h03 : 32'h05)) begin n_fail++; $display("FAIL rr2_first_addr: got %h want %h", m_addr_o, exp_first ? 32'h03 : 32'h05); end
    step();
    m_valid_i = 1'b1; m_dout_i = 32'h33;
    step();
    m_valid_i = 1'b0;
    n_chk++; if ({s1_valid_o, s0_valid_o} !== (exp_first ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr2_first_resp: got s1/s0 %b want %b", {s1_valid_o, s0_valid_o}, exp_first ? 2'b10 : 2'b01); end
    step(2);
    n_chk++; if (m_addr_o !== (exp_first ? 32'h05 : 32'h03)) begin n_fail++; $display("FAIL rr2_second_addr: got %h want %h", m_addr_o, exp_first ? 32'h05 : 32'h03); end
    step();
    m_valid_i = 1'b1; m_dout_i = 32'h44;
    step();
    m_valid_i = 1'b0;
    n_chk++; if ({s1_valid_o, s0_valid_o} !== (exp_first ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL rr2_second_resp: got s1/s0 %b want %b", {s1_valid_o, s0_valid_o}, exp_first ? 2'b01 : 2'b10); end
    step();
  endtask

  task automatic test_timeout;
    do_reset();
    s1_addr_i = 32'h04; s1_rden_i = 1'b1;
    step();
    s1_rden_i = 1'b0;
    step();
    n_chk++; if (m_rden_o !== 1'b1) begin n_fail++; $display("FAIL to_issue: got %b want 1", m_rden_o); end
    step(16);
    n_chk++; if ({s1_valid_o, status_o[3]} !== 2'b00) begin n_fail++; $display("FAIL to_early: got valid/to %b want 00", {s1_valid_o, status_o[3]}); end
    step();
    n_chk++; if (s1_valid_o !== 1'b1) begin n_fail++; $display("FAIL to_valid: got %b want 1", s1_valid_o); end
    n_chk++; if (s1_dout_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL to_dout: got %h want ffffffff", s1_dout_o); end
    n_chk++; if (status_o !== 4'b1001) begin n_fail++; $display("FAIL to_status: got %b want 1001", status_o); end
    step();
    n_chk++; if (status_o !== 4'b1000) begin n_fail++; $display("FAIL to_sticky: got %b want 1000", status_o); end
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    n_chk++; if (status_o !== 4'b0000) begin n_fail++; $display("FAIL to_clear: got %b want 0000", status_o); end
    // completion arriving in the very cycle the counter expires
    s1_rden_i = 1'b1;
    step();
    s1_rden_i = 1'b0;
    step(17);
    m_valid_i = 1'b1; m_dout_i = 32'h5A;
    step();
    m_valid_i = 1'b0;
    n_chk++; if ({s1_valid_o, s1_dout_o, status_o[3]} !== {1'b1, 32'h5A, 1'b0}) begin n_fail++; $display("FAIL to_valid_wins: got v%b d%h to%b want v1 d5a to0", s1_valid_o, s1_dout_o, status_o[3]); end
    step();
  endtask

  task automatic test_drop;
    do_reset();
    rd0 = rd_cnt;
    s1_addr_i = 32'h07; s1_rden_i = 1'b1;
    step();
    s1_addr_i = 32'h09;
    n_chk++; if (s1_ready_o !== 1'b0) begin n_fail++; $display("FAIL drop_ready: got %b want 0", s1_ready_o); end
    step();
    s1_rden_i = 1'b0;
    n_chk++; if ({m_rden_o, m_addr_o} !== {1'b1, 32'h07}) begin n_fail++; $display("FAIL drop_kept: got r%b a%h want r1 a07", m_rden_o, m_addr_o); end
    n_chk++; if (status_o !== 4'b0101) begin n_fail++; $display("FAIL drop_sticky: got %b want 0101", status_o); end
    step();
    m_valid_i = 1'b1; m_dout_i = 32'h77;
    step();
    m_valid_i = 1'b0;
    n_chk++; if ({s1_valid_o, s1_dout_o} !== {1'b1, 32'h77}) begin n_fail++; $display("FAIL drop_resp: got v%b d%h want v1 d77", s1_valid_o, s1_dout_o); end
    step(3);
    n_chk++; if (rd_cnt - rd0 !== 1) begin n_fail++; $display("FAIL drop_one_issue: got %0d want 1", rd_cnt - rd0); end
    n_chk++; if (status_o !== 4'b0100) begin n_fail++; $display("FAIL drop_idle_status: got %b want 0100", status_o); end
  endtask

  task automatic test_mid_reset;
    do_reset();
    s0_addr_i = 32'h01; s0_rden_i = 1'b1;
    step();
    s0_rden_i = 1'b0;
    step(2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_valid_i = 1'b1; m_dout_i = 32'hBAD;
    n_chk++; if ({s0_ready_o, status_o, m_addr_o} !== {1'b1, 4'b0, 32'h0}) begin n_fail++; $display("FAIL mr_state: got rdy%b st%b a%h want rdy1 st0000 a0", s0_ready_o, status_o, m_addr_o); end
    step();
    m_valid_i = 1'b0;
    n_chk++; if ({s0_valid_o, s1_valid_o, status_o, s0_dout_o} !== {2'b00, 4'b0, 32'h0}) begin n_fail++; $display("FAIL mr_stray: got v%b%b st%b d%h want v00 st0000 d0", s0_valid_o, s1_valid_o, status_o, s0_dout_o); end
    s0_addr_i = 32'h06; s0_rden_i = 1'b1;
    step();
    s0_rden_i = 1'b0;
    step();
    n_chk++; if ({m_rden_o, m_addr_o} !== {1'b1, 32'h06}) begin n_fail++; $display("FAIL mr_next_issue: got r%b a%h want r1 a06", m_rden_o, m_addr_o); end
    step();
    m_valid_i = 1'b1; m_dout_i = 32'h66;
    step();
    m_valid_i = 1'b0;
    n_chk++; if ({s0_valid_o, s0_dout_o} !== {1'b1, 32'h66}) begin n_fail++; $display("FAIL mr_next_resp: got v%b d%h want v1 d66", s0_valid_o, s0_dout_o); end
    step();
  endtask

  task automatic test_both_strobes;
    do_reset();
    s0_addr_i = 32'h0A; s0_din_i = 32'h12; s0_wren_i = 1'b1; s0_rden_i = 1'b1;
    step();
    s0_wren_i = 1'b0; s0_rden_i = 1'b0;
    step();
    n_chk++; if ({m_rden_o, m_wren_o, m_addr_o} !== {2'b10, 32'h0A}) begin n_fail++; $display("FAIL both_is_read: got r%b w%b a%h want r1 w0 a0a", m_rden_o, m_wren_o, m_addr_o); end
    step();
    m_valid_i = 1'b1; m_dout_i = 32'h0;
    step();
    m_valid_i = 1'b0;
    step(2);
  endtask

  initial begin
    test_reset();
    test_read();
    test_round_robin();
    test_timeout();
    test_drop();
    test_mid_reset();
    test_both_strobes();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
